// File: rtl/vsync_pkg.sv
// Vertical VGA timing constants, FSM state type and line-to-state helper.
// Shared by the hsync edge detector and the vsync stage.
package vsync_pkg;

   localparam int H_TOTAL = 1600;
   localparam int H_PULSE = 192;
   localparam int H_BP    = 96;
   localparam int H_DISP  = 1280;
   localparam int H_FP    = 32;

   localparam int V_PULSE = 2;
   localparam int V_BP    = 29;
   localparam int V_DISP  = 480;
   localparam int V_FP    = 10;
   localparam int ROW_REP = 5;
   localparam int V_TOTAL = V_PULSE + V_BP + V_DISP + V_FP;

   localparam int LW = 10;

   localparam logic [LW-1:0] L_LAST  = LW'(V_TOTAL - 1);
   localparam logic [LW-1:0] L_BP0   = LW'(V_PULSE);
   localparam logic [LW-1:0] L_DISP0 = LW'(V_PULSE + V_BP);
   localparam logic [LW-1:0] L_FP0   = LW'(V_PULSE + V_BP + V_DISP);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_BP   = 2'd1,
      ST_DISP = 2'd2,
      ST_FP   = 2'd3
   } vstate_t;

   function automatic vstate_t state_of(input logic [LW-1:0] l);
      vstate_t s;
      if (l < L_BP0)
         s = ST_SYNC;
      else if (l < L_DISP0)
         s = ST_BP;
      else if (l < L_FP0)
         s = ST_DISP;
      else
         s = ST_FP;
      return s;
   endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Falling-edge detector on VGA_HSYNC; one line_edge pulse per scanline.
// Ports: clk, reset (async high), hsync in, line_edge out.
module hsync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic hsync,
   output logic line_edge
);

   logic hsync_prev;

   // Resets low so a low hsync right after reset is not taken as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         hsync_prev <= 1'b0;
      else
         hsync_prev <= hsync;
   end

   assign line_edge = hsync_prev & ~hsync;

endmodule

// File: rtl/vsync.sv
// Vertical timing stage: line counter, V FSM, row index, frame strobe.
// Ports: clk, reset, VGA_HSYNC in; VPIXEL, VGA_VSYNC, V_ACTIVE, FRAME_START out.
module vsync
   import vsync_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       VGA_HSYNC,
   output logic [6:0] VPIXEL,
   output logic       VGA_VSYNC,
   output logic       V_ACTIVE,
   output logic       FRAME_START
);

   logic          line_edge;
   logic [LW-1:0] line_cnt;
   logic [LW-1:0] line_nxt;
   logic [2:0]    rep_cnt;
   logic [2:0]    rep_nxt;
   logic [6:0]    vpix_nxt;
   vstate_t       state;
   vstate_t       state_nxt;

   hsync_edge_detect u_edge (
      .clk       (clk),
      .reset     (reset),
      .hsync     (VGA_HSYNC),
      .line_edge (line_edge)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_cnt    <= '0;
         rep_cnt     <= '0;
         VPIXEL      <= '0;
         state       <= ST_SYNC;
         VGA_VSYNC   <= 1'b0;
         V_ACTIVE    <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         line_cnt    <= line_nxt;
         rep_cnt     <= rep_nxt;
         VPIXEL      <= vpix_nxt;
         state       <= state_nxt;
         VGA_VSYNC   <= (state_nxt != ST_SYNC);
         V_ACTIVE    <= (state_nxt == ST_DISP);
         FRAME_START <= line_edge && (line_cnt == L_LAST);
      end
   end

   always_comb begin
      line_nxt = line_cnt;
      rep_nxt  = rep_cnt;
      vpix_nxt = VPIXEL;
      if (line_edge)
         line_nxt = (line_cnt == L_LAST) ? '0 : line_cnt + 1'b1;
      state_nxt = state_of(line_nxt);
      if (line_edge) begin
         // Only advance rows while staying inside the display window;
         // entering or leaving it restarts the row index at 0.
         if (state == ST_DISP && state_nxt == ST_DISP) begin
            if (rep_cnt == 3'(ROW_REP - 1)) begin
               rep_nxt  = '0;
               vpix_nxt = VPIXEL + 7'd1;
            end else begin
               rep_nxt = rep_cnt + 3'd1;
            end
         end else begin
            rep_nxt  = '0;
            vpix_nxt = '0;
         end
      end
   end

endmodule

// File: tb/tb_vsync.sv
// Randomized + directed bench for vsync against a line-number model.
// Model tracks scanline index; outputs derived from frame geometry.
module tb_vsync;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hs = 1'b0;
   logic [6:0] VPIXEL;
   logic       VGA_VSYNC;
   logic       V_ACTIVE;
   logic       FRAME_START;

   int tests = 0;
   int fails = 0;
   int fs_cnt = 0;

   int m_line = 0;
   bit m_prev = 0;
   bit m_fs = 0;

   vsync dut (
      .clk         (clk),
      .reset       (reset),
      .VGA_HSYNC   (hs),
      .VPIXEL      (VPIXEL),
      .VGA_VSYNC   (VGA_VSYNC),
      .V_ACTIVE    (V_ACTIVE),
      .FRAME_START (FRAME_START)
   );

   always #5 clk = ~clk;

   // Model: line number advances on each sampled 1->0 of hsync.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_line = 0;
         m_prev = 0;
         m_fs = 0;
      end else begin
         m_fs = 0;
         if (m_prev && !hs) begin
            m_fs = (m_line == 520);
            m_line = (m_line == 520) ? 0 : m_line + 1;
         end
         m_prev = hs;
      end
   end

   always @(negedge clk) begin
      int  ev;
      bit  ea;
      bit  es;
      ea = (m_line >= 31) && (m_line <= 510);
      es = (m_line >= 2);
      ev = ea ? (m_line - 31) / 5 : 0;
      tests++;
      if (VPIXEL !== 7'(ev) || V_ACTIVE !== ea ||
          VGA_VSYNC !== es || FRAME_START !== m_fs) begin
         fails++;
         if (fails < 20)
            $display("FAIL cycle line=%0d got vp=%0d act=%b vs=%b fs=%b exp vp=%0d act=%b vs=%b fs=%b",
                     m_line, VPIXEL, V_ACTIVE, VGA_VSYNC, FRAME_START,
                     ev, ea, es, m_fs);
      end
      if (FRAME_START === 1'b1)
         fs_cnt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0d exp %0d", nm, act, exp);
      end
   endtask

   task automatic fall(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) hs = 1'b1;
         @(negedge clk) hs = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_vsync", int'(VGA_VSYNC), 0);
      chk("rst_vpix", int'(VPIXEL), 0);
      chk("rst_fs", fs_cnt, 0);

      fall(2);
      chk("l2_vsync", int'(VGA_VSYNC), 1);
      fall(29);
      chk("l31_act", int'(V_ACTIVE), 1);
      chk("l31_vpix", int'(VPIXEL), 0);
      fall(5);
      chk("l36_vpix", int'(VPIXEL), 1);
      fall(4);
      repeat (5000) @(negedge clk);
      chk("hold_lo_vpix", int'(VPIXEL), 1);
      hs = 1'b1;
      repeat (5000) @(negedge clk);
      chk("hold_hi_vpix", int'(VPIXEL), 1);
      chk("hold_hi_act", int'(V_ACTIVE), 1);
      fall(470);
      chk("l510_vpix", int'(VPIXEL), 95);
      fall(1);
      chk("l511_vpix", int'(VPIXEL), 0);
      chk("l511_act", int'(V_ACTIVE), 0);
      fall(9);
      base = fs_cnt;
      chk("pre_wrap_fs", base, 0);
      fall(1);
      repeat (2) @(negedge clk);
      chk("wrap_fs", fs_cnt - base, 1);
      chk("wrap_vsync", int'(VGA_VSYNC), 0);

      fall(200);
      chk("l200_vpix", int'(VPIXEL), 33);
      hs = 1'b1;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_vpix", int'(VPIXEL), 0);
      chk("mid_rst_act", int'(V_ACTIVE), 0);
      chk("mid_rst_vsync", int'(VGA_VSYNC), 0);
      chk("mid_rst_fs", int'(FRAME_START), 0);
      @(negedge clk) reset = 1'b0;
      fall(1);
      chk("rst_l1_vsync", int'(VGA_VSYNC), 0);
      fall(1);
      chk("rst_l2_vsync", int'(VGA_VSYNC), 1);

      for (int l = 0; l < 1700; l++) begin
         @(negedge clk) hs = 1'b1;
         repeat ($urandom_range(0, 5)) @(negedge clk);
         hs = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (l == 900) begin
            #2 reset = 1'b1;
            @(negedge clk) reset = 1'b0;
         end
      end
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
